// File: rtl/prog_clk_divider.sv
// prog_clk_divider
// Multi-channel programmable clock divider. Each channel counts input cycles
// over a runtime-programmable period and drives a registered divided clock
// whose high time is also programmable, plus a one-cycle tick on the first
// cycle of every period. New settings are written into a shadow copy and
// only move into the active copy on a period boundary (or while the channel
// is disabled), so a running clk_out never sees a shortened high or low phase.
// With DEF_DIV = 2*D and DEF_HIGH = D a channel behaves exactly like the
// older fixed toggle divider of divisor D at 50% duty.

module prog_clk_divider #(
    parameter int CNT_W    = 28,
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2,
    parameter int DEF_DIV  = 32000,
    parameter int DEF_HIGH = 16000
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic [CNT_W-1:0]  wr_high,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO    = CNT_W'(2);
    localparam logic [CNT_W-1:0] RST_DIV    = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] RST_HIGH   = CNT_W'(DEF_HIGH);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Effective period: programmed values 0 and 1 are clamped to 2 so a
    // channel can neither stall nor degenerate into a divide-by-one.
    function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] div);
        logic [CNT_W-1:0] p;
        if (div < CNT_TWO) begin
            p = CNT_TWO;
        end else begin
            p = div;
        end
        return p;
    endfunction

    // Last count value of a period for a given programmed divisor.
    function automatic logic [CNT_W-1:0] last_count(input logic [CNT_W-1:0] div);
        return eff_period(div) - CNT_ONE;
    endfunction

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  count_q    [NUM_CH];
    logic [CNT_W-1:0]  count_d    [NUM_CH];
    logic [CNT_W-1:0]  act_div_q  [NUM_CH];
    logic [CNT_W-1:0]  act_div_d  [NUM_CH];
    logic [CNT_W-1:0]  act_high_q [NUM_CH];
    logic [CNT_W-1:0]  act_high_d [NUM_CH];
    logic [CNT_W-1:0]  sh_div_q   [NUM_CH];
    logic [CNT_W-1:0]  sh_div_d   [NUM_CH];
    logic [CNT_W-1:0]  sh_high_q  [NUM_CH];
    logic [CNT_W-1:0]  sh_high_d  [NUM_CH];

    // run_q remembers that the channel was already counting on the previous
    // edge; it separates "enable just rose" from "running and sitting at 0".
    logic [NUM_CH-1:0] run_q;
    logic [NUM_CH-1:0] run_d;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_d;
    logic [NUM_CH-1:0] clk_out_q;
    logic [NUM_CH-1:0] clk_out_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;

    logic [NUM_CH-1:0] wr_sel_s;
    logic [NUM_CH-1:0] wrap_s;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------

    // Decode the write strobe to one channel; indices >= NUM_CH match nothing.
    always_comb begin
        wr_sel_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && (wr_ch == CH_W'(i))) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    // Flag the last cycle of the current period for every running channel.
    always_comb begin
        wrap_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (run_q[i] && (count_q[i] == last_count(act_div_q[i]))) begin
                wrap_s[i] = 1'b1;
            end else begin
                wrap_s[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Per-channel counter, waveform, tick and shadow/active config update.
    always_comb begin
        run_d     = run_q;
        pending_d = pending_q;
        clk_out_d = clk_out_q;
        tick_d    = tick_q;
        for (int i = 0; i < NUM_CH; i++) begin
            count_d[i]    = count_q[i];
            act_div_d[i]  = act_div_q[i];
            act_high_d[i] = act_high_q[i];
            sh_div_d[i]   = sh_div_q[i];
            sh_high_d[i]  = sh_high_q[i];
        end

        for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_en[i]) begin
                // Disabled: park at count 0 with the output low, and let any
                // shadow config fall through since there is no period to break.
                run_d[i]      = 1'b0;
                count_d[i]    = CNT_ZERO;
                clk_out_d[i]  = 1'b0;
                tick_d[i]     = 1'b0;
                act_div_d[i]  = sh_div_q[i];
                act_high_d[i] = sh_high_q[i];
                pending_d[i]  = 1'b0;
            end else if (!run_q[i]) begin
                // Enable just rose: begin a full period immediately.
                run_d[i]      = 1'b1;
                count_d[i]    = CNT_ZERO;
                tick_d[i]     = 1'b1;
                clk_out_d[i]  = (act_high_q[i] != CNT_ZERO);
            end else if (wrap_s[i]) begin
                // Period boundary: start over and adopt the shadow config;
                // the output for count 0 uses the newly adopted high time.
                run_d[i]      = 1'b1;
                count_d[i]    = CNT_ZERO;
                tick_d[i]     = 1'b1;
                act_div_d[i]  = sh_div_q[i];
                act_high_d[i] = sh_high_q[i];
                pending_d[i]  = 1'b0;
                clk_out_d[i]  = (sh_high_q[i] != CNT_ZERO);
            end else begin
                // Mid-period: advance; count stays below P-1 here, so the
                // increment cannot overflow.
                run_d[i]      = 1'b1;
                count_d[i]    = count_q[i] + CNT_ONE;
                tick_d[i]     = 1'b0;
                clk_out_d[i]  = ((count_q[i] + CNT_ONE) < act_high_q[i]);
            end

            // A write only ever lands in the shadow copy; if it coincides with
            // an apply edge, the old shadow is applied and the new one waits.
            if (wr_sel_s[i]) begin
                sh_div_d[i]  = wr_div;
                sh_high_d[i] = wr_high;
                pending_d[i] = 1'b1;
            end else begin
                sh_div_d[i]  = sh_div_d[i];
                sh_high_d[i] = sh_high_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------

    // All channel state, cleared to the default configuration by reset.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            run_q     <= {NUM_CH{1'b0}};
            pending_q <= {NUM_CH{1'b0}};
            clk_out_q <= {NUM_CH{1'b0}};
            tick_q    <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i]    <= CNT_ZERO;
                act_div_q[i]  <= RST_DIV;
                act_high_q[i] <= RST_HIGH;
                sh_div_q[i]   <= RST_DIV;
                sh_high_q[i]  <= RST_HIGH;
            end
        end else begin
            run_q     <= run_d;
            pending_q <= pending_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i]    <= count_d[i];
                act_div_q[i]  <= act_div_d[i];
                act_high_q[i] <= act_high_d[i];
                sh_div_q[i]   <= sh_div_d[i];
                sh_high_q[i]  <= sh_high_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from flops)
    // ------------------------------------------------------------------
    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed testbench for prog_clk_divider: three channels, 8-bit counters,
// scaled defaults (period 8, high 4). A table covers steady running and a
// mid-period reprogram; hand-written sequences cover clamping, writes on a
// wrap cycle, enable drop/raise and reset with a pending write.

module tb_prog_clk_divider;

    localparam int CNT_W = 8;
    localparam int NCH   = 3;
    localparam int CH_W  = 2;

    logic             clock_in;
    logic             reset;
    logic [NCH-1:0]   ch_en;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_div;
    logic [CNT_W-1:0] wr_high;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   pending;

    int checks   = 0;
    int failures = 0;

    prog_clk_divider #(
        .CNT_W(CNT_W), .NUM_CH(NCH), .CH_W(CH_W), .DEF_DIV(8), .DEF_HIGH(4)
    ) dut (
        .clock_in(clock_in), .reset(reset), .ch_en(ch_en),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .wr_high(wr_high),
        .clk_out(clk_out), .tick(tick), .pending(pending)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        logic [NCH-1:0]   en;
        logic             we;
        logic [CH_W-1:0]  ch;
        logic [CNT_W-1:0] dv;
        logic [CNT_W-1:0] hi;
        logic [NCH-1:0]   e_clk;
        logic [NCH-1:0]   e_tick;
        logic [NCH-1:0]   e_pend;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then compare.
    task automatic step(input string tag, input logic [NCH-1:0] en, input logic we,
                        input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] dv,
                        input logic [CNT_W-1:0] hi, input logic [NCH-1:0] e_clk,
                        input logic [NCH-1:0] e_tick, input logic [NCH-1:0] e_pend);
        ch_en   = en;
        wr_en   = we;
        wr_ch   = ch;
        wr_div  = dv;
        wr_high = hi;
        @(posedge clock_in);
        #1;
        chk({tag, " clk_out"}, clk_out, e_clk);
        chk({tag, " tick"},    tick,    e_tick);
        chk({tag, " pending"}, pending, e_pend);
    endtask

    task automatic add(input logic [NCH-1:0] en, input logic we, input logic [CH_W-1:0] ch,
                       input logic [CNT_W-1:0] dv, input logic [CNT_W-1:0] hi,
                       input logic [NCH-1:0] c, input logic [NCH-1:0] t, input logic [NCH-1:0] p);
        vq.push_back('{en, we, ch, dv, hi, c, t, p});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Channel 0 running on defaults 8/4: 11110000, tick on first 1.
        for (int r = 0; r < 2; r++) begin
            add(3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b001, 3'b000);
            add(3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b000, 3'b000);
            add(3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b000, 3'b000);
            add(3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b000, 3'b000);
            add(3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
            add(3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
            add(3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
            add(3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
        end
        // Channel 1 starts on defaults, reprogrammed to 5/2 at count 3.
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b010, 3'b010, 3'b000);
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b010, 3'b000, 3'b000);
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b010, 3'b000, 3'b000);
        add(3'b010, 1'b1, 2'd1, 8'd5, 8'd2, 3'b010, 3'b000, 3'b010);
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b010);
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b010);
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b010);
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b010);
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b010, 3'b010, 3'b000);
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b010, 3'b000, 3'b000);
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b010, 3'b010, 3'b000);
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b010, 3'b000, 3'b000);
        add(3'b010, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);

        // Reset state.
        reset   = 1'b1;
        ch_en   = 3'b001;
        wr_en   = 1'b0;
        wr_ch   = 2'd0;
        wr_div  = 8'd0;
        wr_high = 8'd0;
        #2;
        chk("reset clk_out", clk_out, 3'b000);
        chk("reset tick", tick, 3'b000);
        chk("reset pending", pending, 3'b000);
        @(posedge clock_in);
        #1;
        reset = 1'b0;

        // Table-driven part.
        foreach (vq[k]) begin
            step($sformatf("vec%0d", k), vq[k].en, vq[k].we, vq[k].ch, vq[k].dv, vq[k].hi,
                 vq[k].e_clk, vq[k].e_tick, vq[k].e_pend);
        end

        // Clamp div=0 -> period 2.
        step("div0 wr", 3'b000, 1'b1, 2'd2, 8'd0, 8'd1, 3'b000, 3'b000, 3'b100);
        step("div0 apply", 3'b000, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k < 6; k++)
            step($sformatf("div0 c%0d", k), 3'b100, 1'b0, 2'd0, 8'd0, 8'd0,
                 (k % 2 == 0) ? 3'b100 : 3'b000, (k % 2 == 0) ? 3'b100 : 3'b000, 3'b000);
        // Clamp div=1 -> period 2.
        step("div1 wr", 3'b000, 1'b1, 2'd2, 8'd1, 8'd1, 3'b000, 3'b000, 3'b100);
        step("div1 apply", 3'b000, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k < 4; k++)
            step($sformatf("div1 c%0d", k), 3'b100, 1'b0, 2'd0, 8'd0, 8'd0,
                 (k % 2 == 0) ? 3'b100 : 3'b000, (k % 2 == 0) ? 3'b100 : 3'b000, 3'b000);
        // high=0 -> constant low, tick every 4.
        step("hi0 wr", 3'b000, 1'b1, 2'd2, 8'd4, 8'd0, 3'b000, 3'b000, 3'b100);
        step("hi0 apply", 3'b000, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k < 8; k++)
            step($sformatf("hi0 c%0d", k), 3'b100, 1'b0, 2'd0, 8'd0, 8'd0,
                 3'b000, (k % 4 == 0) ? 3'b100 : 3'b000, 3'b000);
        // high=9, div=6 -> constant high, tick every 6.
        step("hi9 wr", 3'b000, 1'b1, 2'd2, 8'd6, 8'd9, 3'b000, 3'b000, 3'b100);
        step("hi9 apply", 3'b000, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k < 12; k++)
            step($sformatf("hi9 c%0d", k), 3'b100, 1'b0, 2'd0, 8'd0, 8'd0,
                 3'b100, (k % 6 == 0) ? 3'b100 : 3'b000, 3'b000);

        // Write on the wrap cycle: old 6/9 runs one more full period.
        step("wrapwr c0", 3'b100, 1'b1, 2'd2, 8'd3, 8'd1, 3'b100, 3'b100, 3'b100);
        for (int k = 1; k < 6; k++)
            step($sformatf("wrapwr c%0d", k), 3'b100, 1'b0, 2'd0, 8'd0, 8'd0,
                 3'b100, 3'b000, 3'b100);
        step("wrapwr new c0", 3'b100, 1'b0, 2'd0, 8'd0, 8'd0, 3'b100, 3'b100, 3'b000);
        step("wrapwr new c1", 3'b100, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
        step("wrapwr new c2", 3'b100, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
        step("wrapwr new c0b", 3'b100, 1'b0, 2'd0, 8'd0, 8'd0, 3'b100, 3'b100, 3'b000);

        // Enable drop at count 3, raise two cycles later: full restart.
        for (int k = 0; k < 4; k++)
            step($sformatf("endrop c%0d", k), 3'b001, 1'b0, 2'd0, 8'd0, 8'd0,
                 3'b001, (k == 0) ? 3'b001 : 3'b000, 3'b000);
        step("endrop off0", 3'b000, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
        step("endrop off1", 3'b000, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k < 5; k++)
            step($sformatf("enrise c%0d", k), 3'b001, 1'b0, 2'd0, 8'd0, 8'd0,
                 (k < 4) ? 3'b001 : 3'b000, (k == 0) ? 3'b001 : 3'b000, 3'b000);

        // Out-of-range channel write is ignored, then a real pending write.
        step("badch", 3'b001, 1'b1, 2'd3, 8'd2, 8'd2, 3'b000, 3'b000, 3'b000);
        step("pendwr", 3'b001, 1'b1, 2'd0, 8'd3, 8'd1, 3'b000, 3'b000, 3'b001);
        ch_en = 3'b001;
        wr_en = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("async rst clk_out", clk_out, 3'b000);
        chk("async rst tick", tick, 3'b000);
        chk("async rst pending", pending, 3'b000);
        @(posedge clock_in);
        #1;
        chk("held rst clk_out", clk_out, 3'b000);
        reset = 1'b0;
        // Defaults 8/4 restored; a surviving 3/1 shadow would show after 8 cycles.
        for (int k = 0; k < 12; k++)
            step($sformatf("postrst c%0d", k), 3'b001, 1'b0, 2'd0, 8'd0, 8'd0,
                 (k % 8 < 4) ? 3'b001 : 3'b000, (k % 8 == 0) ? 3'b001 : 3'b000, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
